// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the ram built-in self-test slice:
//   - default geometry of the 8-bit single-port ram under test
//   - FSM state encoding of the BIST controller
//   - the data pattern written to / expected from each location
// No ports (package).
// ---------------------------------------------------------------------------
package ram_pkg;

  localparam int WORD_DEF   = 8;    // ram data width
  localparam int ADDR_DEF   = 8;    // ram address width
  localparam int MEMS_DEF   = 256;  // number of locations exercised
  localparam int OFFSET_DEF = 10;   // pattern offset added to the address

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_ASSERT  = 3'd1,
    ST_WR_RELEASE = 3'd2,
    ST_RD_ADDR    = 3'd3,
    ST_RD_CHECK   = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  // Pattern for one location: (address + offset), optionally inverted.
  // Computed at 32 bits; callers keep the low WORD bits, which gives the
  // wrap-around modulo 2**WORD for free.
  function automatic logic [31:0] pattern_calc(input logic [31:0] addr,
                                               input logic [31:0] offset,
                                               input logic        inv);
    logic [31:0] sum;
    sum = addr + offset;
    return inv ? ~sum : sum;
  endfunction

endpackage

// File: rtl/ram_bist_pattern.sv
// ---------------------------------------------------------------------------
// ram_bist_pattern
// Combinational expected-data generator. The same instance supplies the
// write data during the fill phase and the reference value during the
// read-back compare, so both sides can never disagree on the pattern.
// Ports:
//   addr  in   ADDR  location whose pattern is wanted
//   inv   in   1     0 = addr+OFFSET, 1 = bitwise NOT of addr+OFFSET
//   data  out  WORD  pattern value, wrapped to WORD bits
// ---------------------------------------------------------------------------
module ram_bist_pattern
  import ram_pkg::*;
#(
  parameter int WORD   = WORD_DEF,
  parameter int ADDR   = ADDR_DEF,
  parameter int OFFSET = OFFSET_DEF
) (
  input  logic [ADDR-1:0] addr,
  input  logic            inv,
  output logic [WORD-1:0] data
);

  assign data = WORD'(pattern_calc(32'(addr), 32'(OFFSET), inv));

endmodule

// File: rtl/ram_bist_ctrl.sv
// ---------------------------------------------------------------------------
// ram_bist_ctrl
// Built-in self-test master for the single-port ram. On start it writes a
// pattern into every location 0..MEMS-1 (two cycles per location: strobe
// high, then strobe released with address held), then reads every location
// back (address settle cycle, then compare) and reports the result.
// All ram-side outputs are registered; the external mux only needs busy.
// Ports:
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous active-high reset
//   start      in   1       begin a run (sampled in IDLE or DONE only)
//   inv        in   1       pattern select, captured together with start
//   ad         out  ADDR    ram address
//   di         out  WORD    ram write data
//   w          out  1       ram write strobe
//   cs         out  1       ram chip select
//   do_in      in   WORD    ram read data (combinational from ad)
//   busy       out  1       run in progress
//   done       out  1       run finished, held until next start or rst
//   pass       out  1       valid with done: no mismatching location
//   err_count  out  ADDR+1  number of mismatching locations this run
//   fail_addr  out  ADDR    first mismatching address, 0 if none
// ---------------------------------------------------------------------------
module ram_bist_ctrl
  import ram_pkg::*;
#(
  parameter int WORD   = WORD_DEF,
  parameter int ADDR   = ADDR_DEF,
  parameter int MEMS   = MEMS_DEF,
  parameter int OFFSET = OFFSET_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            inv,
  output logic [ADDR-1:0] ad,
  output logic [WORD-1:0] di,
  output logic            w,
  output logic            cs,
  input  logic [WORD-1:0] do_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ADDR:0]   err_count,
  output logic [ADDR-1:0] fail_addr
);

  localparam logic [ADDR-1:0] LAST = ADDR'(MEMS - 1);

  state_t          state, state_n;
  logic [ADDR-1:0] addr, addr_n;
  logic [ADDR-1:0] ad_n;
  logic [WORD-1:0] di_n;
  logic            w_n, cs_n;
  logic            busy_n, done_n, pass_n;
  logic [ADDR:0]   err_n;
  logic [ADDR-1:0] fail_n;
  logic            inv_q, inv_n;

  logic [ADDR-1:0] pat_addr;
  logic            pat_inv;
  logic [WORD-1:0] pat_data;

  // Shared pattern generator: the FSM steers its address to whichever
  // location is being written next or compared now.
  ram_bist_pattern #(
    .WORD   (WORD),
    .ADDR   (ADDR),
    .OFFSET (OFFSET)
  ) u_pattern (
    .addr (pat_addr),
    .inv  (pat_inv),
    .data (pat_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      ad        <= '0;
      di        <= '0;
      w         <= 1'b0;
      cs        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      inv_q     <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      ad        <= ad_n;
      di        <= di_n;
      w         <= w_n;
      cs        <= cs_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      err_count <= err_n;
      fail_addr <= fail_n;
      inv_q     <= inv_n;
    end
  end

  always_comb begin
    state_n  = state;
    addr_n   = addr;
    ad_n     = ad;
    di_n     = di;
    w_n      = w;
    cs_n     = cs;
    busy_n   = busy;
    done_n   = done;
    pass_n   = pass;
    err_n    = err_count;
    fail_n   = fail_addr;
    inv_n    = inv_q;
    pat_addr = addr;
    pat_inv  = inv_q;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        // The latch is not loaded yet on the start edge, so the first
        // write uses the live inv input.
        pat_addr = '0;
        pat_inv  = inv;
        if (start) begin
          state_n = ST_WR_ASSERT;
          addr_n  = '0;
          inv_n   = inv;
          err_n   = '0;
          fail_n  = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          ad_n    = '0;
          di_n    = pat_data;
          w_n     = 1'b1;
          cs_n    = 1'b1;
        end
      end

      ST_WR_ASSERT: begin
        // Drop the strobe while address and data stay put.
        state_n = ST_WR_RELEASE;
        w_n     = 1'b0;
        cs_n    = 1'b0;
      end

      ST_WR_RELEASE: begin
        if (addr == LAST) begin
          state_n = ST_RD_ADDR;
          addr_n  = '0;
          ad_n    = '0;
          w_n     = 1'b0;
          cs_n    = 1'b1;
        end else begin
          pat_addr = addr + ADDR'(1);
          state_n  = ST_WR_ASSERT;
          addr_n   = addr + ADDR'(1);
          ad_n     = addr + ADDR'(1);
          di_n     = pat_data;
          w_n      = 1'b1;
          cs_n     = 1'b1;
        end
      end

      ST_RD_ADDR: begin
        // One settle cycle so do_in reflects the new address.
        state_n = ST_RD_CHECK;
        cs_n    = 1'b1;
        w_n     = 1'b0;
      end

      ST_RD_CHECK: begin
        pat_addr = addr;
        if (do_in != pat_data) begin
          err_n = err_count + (ADDR+1)'(1);
          if (err_count == '0) begin
            fail_n = addr;
          end
        end
        if (addr == LAST) begin
          state_n = ST_DONE;
          cs_n    = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == '0);
        end else begin
          state_n = ST_RD_ADDR;
          addr_n  = addr + ADDR'(1);
          ad_n    = addr + ADDR'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
module tb_ram_bist_ctrl;

  localparam int M = 256;

  logic       clk;
  logic       rst;
  logic       start;
  logic       inv;
  logic [7:0] ad;
  logic [7:0] di;
  logic       w;
  logic       cs;
  logic [7:0] do_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [8:0] err_count;
  logic [7:0] fail_addr;

  int n_checks = 0;
  int n_errors = 0;

  // 0 = fault-free, 1 = data bit 3 stuck at 0, 2 = address bit 7 ignored
  int fault = 0;

  logic [7:0] mem [M];

  ram_bist_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .inv       (inv),
    .ad        (ad),
    .di        (di),
    .w         (w),
    .cs        (cs),
    .do_in     (do_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_addr (fail_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ram environment with optional planted faults
  function automatic int eff_addr(input int a);
    return (fault == 2) ? (a % 128) : a;
  endfunction

  function automatic logic [7:0] faulty(input logic [7:0] d);
    return (fault == 1) ? (d & 8'hF7) : d;
  endfunction

  always @(posedge clk) begin
    if (w && cs) mem[eff_addr(int'(ad))] <= faulty(di);
  end

  assign do_in = mem[eff_addr(int'(ad))];

  // Reference pattern from plain arithmetic: (a+10) mod 256, inverted as 255-v
  function automatic int model_pat(input int a, input bit iv);
    int v;
    v = (a + 10) % 256;
    if (iv) v = 255 - v;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a run is a timeline of 4*M cycles after the start edge
  bit m_valid   = 0;
  bit m_reset   = 0;
  bit m_running = 0;
  bit m_done    = 0;
  int m_k       = 0;
  bit m_inv     = 0;
  bit m_mism [M];

  always @(posedge clk) begin
    if (rst) begin
      m_valid   = 1;
      m_reset   = 1;
      m_running = 0;
      m_done    = 0;
      m_k       = 0;
    end else if (m_valid && !m_running && start) begin
      int st [M];
      m_running = 1;
      m_reset   = 0;
      m_done    = 0;
      m_k       = 0;
      m_inv     = inv;
      for (int a = 0; a < M; a++) st[a] = 0;
      for (int a = 0; a < M; a++) st[eff_addr(a)] = int'(faulty(8'(model_pat(a, m_inv))));
      for (int a = 0; a < M; a++) m_mism[a] = (st[eff_addr(a)] != model_pat(a, m_inv));
    end else if (m_running) begin
      m_k++;
      if (m_k == 4*M) begin
        m_running = 0;
        m_done    = 1;
      end
    end
  end

  // Compare process: every cycle once reset has been seen
  always @(negedge clk) begin
    if (m_valid) begin
      int a, nreads, tot, first;
      bit ew;
      if (m_reset) begin
        checkOutput("rst_ad", int'(ad), 0);
        checkOutput("rst_di", int'(di), 0);
        checkOutput("rst_w", int'(w), 0);
        checkOutput("rst_cs", int'(cs), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_pass", int'(pass), 0);
        checkOutput("rst_err", int'(err_count), 0);
        checkOutput("rst_fail", int'(fail_addr), 0);
      end else begin
        if (m_running) begin
          if (m_k < 2*M) begin
            a  = m_k / 2;
            ew = (m_k % 2) == 0;
            checkOutput("wr_ad", int'(ad), a);
            checkOutput("wr_di", int'(di), model_pat(a, m_inv));
            checkOutput("wr_w", int'(w), int'(ew));
            checkOutput("wr_cs", int'(cs), int'(ew));
            nreads = 0;
          end else begin
            a = (m_k - 2*M) / 2;
            checkOutput("rd_ad", int'(ad), a);
            checkOutput("rd_w", int'(w), 0);
            checkOutput("rd_cs", int'(cs), 1);
            nreads = (m_k - 2*M) / 2;
          end
          checkOutput("run_busy", int'(busy), 1);
          checkOutput("run_done", int'(done), 0);
          checkOutput("run_pass", int'(pass), 0);
        end else begin
          nreads = M;
          checkOutput("fin_ad", int'(ad), M - 1);
          checkOutput("fin_w", int'(w), 0);
          checkOutput("fin_cs", int'(cs), 0);
          checkOutput("fin_busy", int'(busy), 0);
          checkOutput("fin_done", int'(done), 1);
        end
        tot   = 0;
        first = 0;
        for (int i = 0; i < nreads; i++) begin
          if (m_mism[i]) begin
            if (tot == 0) first = i;
            tot++;
          end
        end
        checkOutput("err_count", int'(err_count), tot);
        checkOutput("fail_addr", int'(fail_addr), first);
        if (m_done) checkOutput("fin_pass", int'(pass), int'(tot == 0));
      end
    end
  end

  // One cycle of stimulus, changed on the inactive edge
  task automatic applyStimulus(input logic s, input logic i, input logic r);
    @(negedge clk);
    start = s;
    inv   = i;
    rst   = r;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // Start a run and wait (bounded) for done; extra start pulses at p1/p2
  task automatic runTest(input bit inv_v, input int p1, input int p2);
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 0;
    applyStimulus(1'b1, inv_v, 1'b0);
    for (int c = 0; c <= 4*M + 8; c++) begin
      applyStimulus(1'(c == p1 || c == p2), 1'($urandom_range(0, 1)), 1'b0);
      if (c == 0) checkOutput("done_drop", int'(done), 0);
      cnt = c;
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (seen) checkOutput("latency", cnt, 4*M);
    else      checkOutput("done_timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < M; i++) mem[i] = 8'h00;
    rst   = 1'b1;
    start = 1'b0;
    inv   = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    idleCycles(3);

    $display("[TB] fault-free run, inv=0");
    fault = 0;
    runTest(1'b0, -1, -1);
    checkOutput("t1_pass", int'(pass), 1);
    checkOutput("t1_err", int'(err_count), 0);
    checkOutput("t1_mem5", int'(mem[5]), 15);
    checkOutput("t1_mem250", int'(mem[250]), 4);
    idleCycles(4);

    $display("[TB] fault-free run, inv=1");
    runTest(1'b1, -1, -1);
    checkOutput("t2_pass", int'(pass), 1);
    checkOutput("t2_mem0", int'(mem[0]), 245);
    idleCycles(2);

    $display("[TB] stuck-at-0 on data bit 3");
    fault = 1;
    runTest(1'b0, -1, -1);
    checkOutput("t3_err", int'(err_count), 128);
    checkOutput("t3_fail", int'(fail_addr), 0);
    checkOutput("t3_pass", int'(pass), 0);
    idleCycles(2);

    $display("[TB] address bit 7 aliasing");
    fault = 2;
    runTest(1'($urandom_range(0, 1)), -1, -1);
    checkOutput("t4_err", int'(err_count), 128);
    checkOutput("t4_fail", int'(fail_addr), 0);
    checkOutput("t4_pass", int'(pass), 0);
    idleCycles(2);

    $display("[TB] reset in the middle of a run");
    fault = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycles(300);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t5_w", int'(w), 0);
    checkOutput("t5_cs", int'(cs), 0);
    checkOutput("t5_busy", int'(busy), 0);
    idleCycles(3);
    runTest(1'b0, -1, -1);
    checkOutput("t5_pass", int'(pass), 1);

    $display("[TB] start pulses while busy, then restart from done");
    idleCycles(2);
    runTest(1'b0, 10, 500);
    runTest(1'b1, -1, -1);
    checkOutput("t6_pass", int'(pass), 1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 3; r++) begin
      fault = int'($urandom_range(0, 2));
      idleCycles(int'($urandom_range(0, 5)));
      runTest(1'($urandom_range(0, 1)), int'($urandom_range(1, 1000)), int'($urandom_range(1, 1000)));
    end

    idleCycles(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
